// File: rtl/rds_block_sync.sv
// RDS receive block synchroniser: finds block boundaries via offset-word syndromes and emits
// 16-bit information words. Optional group assembly enabled by `define RDS_GROUP_ASSEMBLY_EN.
module rds_block_sync #(
  parameter int unsigned MAX_BAD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [15:0] blk_data,
  output logic [2:0]  blk_id,
  output logic        blk_valid,
  output logic        blk_err,
  output logic        synced
`ifdef RDS_GROUP_ASSEMBLY_EN
  ,
  output logic [63:0] grp_data,
  output logic [3:0]  grp_err,
  output logic        grp_valid
`endif
);

  localparam logic [1:0] StSearch  = 2'd0;
  localparam logic [1:0] StConfirm = 2'd1;
  localparam logic [1:0] StSync    = 2'd2;

  localparam logic [2:0] IdA    = 3'd0;
  localparam logic [2:0] IdB    = 3'd1;
  localparam logic [2:0] IdC    = 3'd2;
  localparam logic [2:0] IdCp   = 3'd3;
  localparam logic [2:0] IdD    = 3'd4;
  localparam logic [2:0] IdNone = 3'd7;

  localparam logic [9:0] OffA  = 10'h0FC;
  localparam logic [9:0] OffB  = 10'h198;
  localparam logic [9:0] OffC  = 10'h168;
  localparam logic [9:0] OffCp = 10'h350;
  localparam logic [9:0] OffD  = 10'h1B4;

  logic [25:0] sr_q, sr_d;
  logic [1:0]  state_q, state_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [2:0]  exp_q, exp_d;
  logic [3:0]  bad_cnt_q, bad_cnt_d;
  logic        eval_q, eval_d;
  logic        loss_q, loss_d;
  logic        synced_d;

  logic [9:0]  syndrome;
  logic        hit, exp_hit;
  logic [2:0]  match_id;
  logic        emit, emit_err;
  logic [2:0]  emit_id;

  // data(x) * x^10 mod g(x), g = x^10+x^8+x^7+x^5+x^4+x^3+1
  function automatic logic [9:0] crc10(input logic [15:0] d);
    logic [9:0] r;
    logic       fb;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      fb = d[i] ^ r[9];
      r  = {r[8:0], 1'b0};
      if (fb) r = r ^ 10'h1B9;
    end
    return r;
  endfunction

  function automatic logic [2:0] next_id(input logic [2:0] id);
    case (id)
      IdA:       return IdB;
      IdB:       return IdC;
      IdC, IdCp: return IdD;
      default:   return IdA;
    endcase
  endfunction

  always_comb begin
    syndrome = crc10(sr_q[25:10]) ^ sr_q[9:0];
    hit      = 1'b1;
    match_id = IdNone;
    if      (syndrome == OffA)  match_id = IdA;
    else if (syndrome == OffB)  match_id = IdB;
    else if (syndrome == OffC)  match_id = IdC;
    else if (syndrome == OffCp) match_id = IdCp;
    else if (syndrome == OffD)  match_id = IdD;
    else                        hit = 1'b0;
    // An expected C accepts either C or C'
    exp_hit = hit && ((match_id == exp_q) || (exp_q == IdC && match_id == IdCp));
  end

  always_comb begin
    sr_d      = bit_valid ? {sr_q[24:0], bit_in} : sr_q;
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    exp_d     = exp_q;
    bad_cnt_d = bad_cnt_q;
    eval_d    = 1'b0;
    loss_d    = 1'b0;
    synced_d  = loss_q ? 1'b0 : synced;
    emit      = 1'b0;
    emit_id   = IdNone;
    emit_err  = 1'b0;

    if (eval_q) begin
      case (state_q)
        StSearch: begin
          if (hit) begin
            state_d  = StConfirm;
            exp_d    = next_id(match_id);
            bitcnt_d = '0;
          end
        end
        StConfirm: begin
          if (exp_hit) begin
            state_d   = StSync;
            emit      = 1'b1;
            emit_id   = match_id;
            synced_d  = 1'b1;
            bad_cnt_d = '0;
            exp_d     = next_id(match_id);
          end else begin
            state_d  = StSearch;
            bitcnt_d = '0;
          end
        end
        StSync: begin
          emit  = 1'b1;
          exp_d = next_id(exp_q);
          if (exp_hit) begin
            emit_id   = match_id;
            bad_cnt_d = '0;
          end else begin
            emit_id   = exp_q;
            emit_err  = 1'b1;
            bad_cnt_d = bad_cnt_q + 4'd1;
            // synced stays high for this strobe and drops via loss_q next cycle
            if (bad_cnt_q + 4'd1 == 4'(MAX_BAD)) begin
              state_d   = StSearch;
              bitcnt_d  = '0;
              bad_cnt_d = '0;
              loss_d    = 1'b1;
            end
          end
        end
        default: begin
          state_d  = StSearch;
          bitcnt_d = '0;
        end
      endcase
    end

    // A bit arriving alongside an evaluation belongs to the post-evaluation state
    if (bit_valid) begin
      if (state_d == StSearch) begin
        eval_d = 1'b1;
      end else if (bitcnt_d == 5'd25) begin
        bitcnt_d = '0;
        eval_d   = 1'b1;
      end else begin
        bitcnt_d = bitcnt_d + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q      <= '0;
      state_q   <= StSearch;
      bitcnt_q  <= '0;
      exp_q     <= IdA;
      bad_cnt_q <= '0;
      eval_q    <= 1'b0;
      loss_q    <= 1'b0;
      blk_data  <= '0;
      blk_id    <= IdNone;
      blk_valid <= 1'b0;
      blk_err   <= 1'b0;
      synced    <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      exp_q     <= exp_d;
      bad_cnt_q <= bad_cnt_d;
      eval_q    <= eval_d;
      loss_q    <= loss_d;
      blk_valid <= emit;
      synced    <= synced_d;
      if (emit) begin
        blk_data <= sr_q[25:10];
        blk_id   <= emit_id;
        blk_err  <= emit_err;
      end
    end
  end

`ifdef RDS_GROUP_ASSEMBLY_EN
  logic [63:0] grp_buf_q;
  logic [3:0]  grp_ebuf_q;
  logic [2:0]  grp_cnt_q;
  logic        grp_pend_q;

  // grp_cnt_q counts blocks collected in order since the last A
  always_ff @(posedge clk) begin
    if (reset) begin
      grp_buf_q  <= '0;
      grp_ebuf_q <= '0;
      grp_cnt_q  <= '0;
      grp_pend_q <= 1'b0;
      grp_data   <= '0;
      grp_err    <= '0;
      grp_valid  <= 1'b0;
    end else begin
      grp_pend_q <= 1'b0;
      grp_valid  <= grp_pend_q;
      if (grp_pend_q) begin
        grp_data <= grp_buf_q;
        grp_err  <= grp_ebuf_q;
      end
      if (emit) begin
        case (emit_id)
          IdA: begin
            grp_buf_q[63:48] <= sr_q[25:10];
            grp_ebuf_q[3]    <= emit_err;
            grp_cnt_q        <= 3'd1;
          end
          IdB: begin
            if (grp_cnt_q == 3'd1) begin
              grp_buf_q[47:32] <= sr_q[25:10];
              grp_ebuf_q[2]    <= emit_err;
              grp_cnt_q        <= 3'd2;
            end else begin
              grp_cnt_q <= '0;
            end
          end
          IdC, IdCp: begin
            if (grp_cnt_q == 3'd2) begin
              grp_buf_q[31:16] <= sr_q[25:10];
              grp_ebuf_q[1]    <= emit_err;
              grp_cnt_q        <= 3'd3;
            end else begin
              grp_cnt_q <= '0;
            end
          end
          IdD: begin
            if (grp_cnt_q == 3'd3) begin
              grp_buf_q[15:0] <= sr_q[25:10];
              grp_ebuf_q[0]   <= emit_err;
              grp_pend_q      <= 1'b1;
            end
            grp_cnt_q <= '0;
          end
          default: grp_cnt_q <= '0;
        endcase
        if (loss_d) grp_cnt_q <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rds_block_sync.sv
// Scoreboard bench for rds_block_sync: a bit-level reference model predicts every emitted block.
module tb_rds_block_sync;
  localparam int unsigned MaxBad = 8;

  logic        clk = 1'b0;
  logic        reset, bit_in, bit_valid;
  logic [15:0] blk_data;
  logic [2:0]  blk_id;
  logic        blk_valid, blk_err, synced;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rds_block_sync #(.MAX_BAD(MaxBad)) dut (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .blk_data  (blk_data),
    .blk_id    (blk_id),
    .blk_valid (blk_valid),
    .blk_err   (blk_err),
    .synced    (synced)
  );

  typedef struct {
    logic [2:0]  id;
    logic [15:0] data;
    logic        err;
    logic        lose;
    int unsigned due;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic lose_pend = 1'b0;

  logic [9:0] offs [5] = '{10'h0FC, 10'h198, 10'h168, 10'h350, 10'h1B4};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Remainder of the whole 26-bit block polynomial modulo g(x) is the syndrome
  function automatic logic [9:0] pmod(input logic [25:0] v);
    logic [25:0] r;
    r = v;
    for (int i = 25; i >= 10; i--)
      if (r[i]) r = r ^ (26'h5B9 << (i - 10));
    return r[9:0];
  endfunction

  function automatic int type_of(input logic [25:0] w);
    logic [9:0] s;
    s = pmod(w);
    for (int k = 0; k < 5; k++) if (s == offs[k]) return k;
    return -1;
  endfunction

  // Group position: A=0, B=1, C/C'=2, D=3
  function automatic int slot_of(input int id);
    if (id <= 1) return id;
    if (id <= 3) return 2;
    return 3;
  endfunction

  function automatic logic [25:0] mk(input logic [15:0] d, input int id, input logic [9:0] flip);
    return {d, pmod({d, 10'b0}) ^ offs[id] ^ flip};
  endfunction

  // Reference model: 0 = hunting, 1 = confirming, 2 = locked
  logic [25:0] m_win;
  int m_mode, m_cnt, m_slot, m_bad;

  task automatic model_reset();
    m_win = '0; m_mode = 0; m_cnt = 0; m_slot = 0; m_bad = 0;
  endtask

  task automatic push(input int id, input logic err, input logic lose, input int unsigned now);
    exp_t e;
    e.id = 3'(id); e.data = m_win[25:10]; e.err = err; e.lose = lose; e.due = now + 1;
    sbq.push_back(e);
  endtask

  task automatic model_bit(input logic b, input int unsigned now);
    int  t;
    bit  ok;
    m_win = {m_win[24:0], b};
    t  = type_of(m_win);
    ok = (t >= 0) && (slot_of(t) == m_slot);
    if (m_mode == 0) begin
      if (t >= 0) begin
        m_mode = 1; m_cnt = 0; m_slot = (slot_of(t) + 1) % 4;
      end
    end else begin
      m_cnt++;
      if (m_cnt == 26) begin
        m_cnt = 0;
        if (m_mode == 1) begin
          if (ok) begin
            m_mode = 2; m_bad = 0; push(t, 1'b0, 1'b0, now);
            m_slot = (m_slot + 1) % 4;
          end else begin
            m_mode = 0;
          end
        end else begin
          if (ok) begin
            m_bad = 0; push(t, 1'b0, 1'b0, now);
          end else begin
            m_bad++;
            push((m_slot == 3) ? 4 : m_slot, 1'b1, m_bad == int'(MaxBad), now);
            if (m_bad == int'(MaxBad)) begin
              m_mode = 0; m_bad = 0;
            end
          end
          m_slot = (m_slot + 1) % 4;
        end
      end
    end
  endtask

  // Monitor: pops the scoreboard on every strobe
  always @(negedge clk) begin
    if (!reset) begin
      if (lose_pend) begin
        chk("sync_drop", synced, 0);
        lose_pend = 1'b0;
      end
      if (blk_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_strobe", blk_valid, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("blk_id", blk_id, e.id);
          chk("blk_data", blk_data, e.data);
          chk("blk_err", blk_err, e.err);
          chk("synced_at_strobe", synced, 1);
          chk("latency", cyc, e.due);
          lose_pend = e.lose;
        end
      end
    end
  end

  // Called at a negedge; gap 0 means random spacing 1..50
  task automatic send_bit(input logic b, input int gap);
    int g;
    g = (gap == 0) ? int'($urandom_range(1, 50)) : gap;
    bit_in    = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    model_bit(b, cyc);
    repeat (g - 1) @(negedge clk);
  endtask

  task automatic send_word(input logic [25:0] w, input int gap);
    for (int i = 25; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic send_zeros(input int n, input int gap);
    for (int i = 0; i < n; i++) send_bit(1'b0, gap);
  endtask

  task automatic check_sync(input string name);
    repeat (2) @(negedge clk);
    chk(name, synced, (m_mode == 2) ? 1 : 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_blk_data"}, blk_data, 0);
    chk({tag, "_blk_id"}, blk_id, 7);
    chk({tag, "_blk_valid"}, blk_valid, 0);
    chk({tag, "_blk_err"}, blk_err, 0);
    chk({tag, "_synced"}, synced, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    model_reset();
    sbq.delete();
    lose_pend = 1'b0;
  endtask

  initial begin
    int slot, id;
    logic [9:0] flip;
    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;

    // Acquisition
    send_zeros(20, 4);
    send_word(mk(16'h0000, 0, '0), 4);
    send_word(mk(16'h0000, 1, '0), 4);
    check_sync("acq_synced");

    // Steady sync over two groups
    send_word(mk(16'h0000, 3, '0), 4);
    send_word(mk(16'h0000, 4, '0), 4);
    send_word(mk(16'h0000, 0, '0), 4);
    send_word(mk(16'h0000, 1, '0), 4);
    send_word(mk(16'h0000, 2, '0), 4);
    send_word(mk(16'h0000, 4, '0), 4);
    check_sync("steady_synced");

    // Single bad D, then good A
    send_word(mk(16'h0000, 0, '0), 2);
    send_word(mk(16'h1234, 1, '0), 2);
    send_word(mk(16'hBEEF, 2, '0), 2);
    send_word(mk(16'h0000, 4, 10'h001), 2);
    check_sync("single_err_synced");
    send_word(mk(16'h0000, 0, '0), 2);

    // Loss of sync on MaxBad all-ones blocks
    for (int k = 0; k < int'(MaxBad); k++) send_word(26'h3FFFFFF, 1);
    check_sync("loss_synced");
    send_zeros(30, 1);

    // Randomised strobe gaps
    pulse_reset();
    send_zeros(20, 0);
    send_word(mk(16'h0000, 0, '0), 0);
    send_word(mk(16'h0000, 1, '0), 0);
    check_sync("gaps_synced");
    send_word(mk(16'h0000, 2, '0), 1);
    send_word(mk(16'h0000, 4, '0), 1);

    // Reset in the middle of a block
    for (int i = 25; i >= 13; i--) send_bit(mk(16'hA5A5, 0, '0) >> i, 1);
    pulse_reset();
    send_zeros(20, 1);
    send_word(mk(16'h0000, 0, '0), 1);
    send_word(mk(16'h0000, 1, '0), 1);
    check_sync("reacq_synced");

    // Random groups, corruption and slips
    slot = 2;
    for (int n = 0; n < 40; n++) begin
      id   = (slot == 3) ? 4 : (slot == 2 ? 2 + int'($urandom_range(0, 1)) : slot);
      flip = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(1, 1023)) : 10'h000;
      if ($urandom_range(0, 19) == 0)
        for (int j = 0; j < int'($urandom_range(1, 30)); j++) send_bit(1'($urandom), 1);
      send_word(mk(16'($urandom), id, flip), int'($urandom_range(1, 3)));
      slot = (slot + 1) % 4;
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
